// File: rtl/palette_pkg.sv
// Shared palette constants and types for the sprite palette arbiter.
package palette_pkg;

   localparam int unsigned NUM_COLORS = 18;
   localparam int unsigned IDX_W      = 5;

   localparam logic [IDX_W-1:0] TRANSPARENT_IDX = 5'd0;
   localparam logic [IDX_W-1:0] BG_IDX          = 5'd2;
   localparam logic [IDX_W-1:0] FLASH_IDX       = 5'd10;

   typedef struct packed {
      logic [7:0] r;
      logic [7:0] g;
      logic [7:0] b;
   } rgb_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FLASH = 1'b1
   } flash_state_t;

endpackage

// File: rtl/sprite_palette_arbiter_flash_ctrl.sv
// Hit-flash FSM: counts frames of a flash and toggles the on/off phase.
module flash_ctrl
   import palette_pkg::*;
#(
   parameter int FLASH_FRAMES = 60,
   parameter int FLASH_PERIOD = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic frame_start,
   input  logic hit_pulse,
   output logic phase_on,
   output logic flash_active
);

   localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
   localparam int PW = (FLASH_PERIOD > 1) ? $clog2(FLASH_PERIOD) : 1;

   flash_state_t   state, state_n;
   logic [FW-1:0]  frame_cnt, frame_n;
   logic [PW-1:0]  phase_cnt, phase_n;
   logic           on_n;

   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         frame_cnt    <= '0;
         phase_cnt    <= '0;
         phase_on     <= 1'b0;
         flash_active <= 1'b0;
      end else begin
         state        <= state_n;
         frame_cnt    <= frame_n;
         phase_cnt    <= phase_n;
         phase_on     <= on_n;
         flash_active <= (state_n == FLASH);
      end
   end

   // A hit always restarts the flash and swallows a coincident frame tick.
   always_comb begin
      state_n = state;
      frame_n = frame_cnt;
      phase_n = phase_cnt;
      on_n    = phase_on;
      if (hit_pulse) begin
         state_n = FLASH;
         frame_n = '0;
         phase_n = '0;
         on_n    = 1'b1;
      end else if (state == FLASH && frame_start) begin
         frame_n = frame_cnt + 1'b1;
         if (phase_cnt == PW'(FLASH_PERIOD - 1)) begin
            phase_n = '0;
            on_n    = ~phase_on;
         end else begin
            phase_n = phase_cnt + 1'b1;
         end
         if (frame_cnt == FW'(FLASH_FRAMES - 1)) begin
            state_n = IDLE;
            frame_n = '0;
            phase_n = '0;
            on_n    = 1'b0;
         end
      end
   end

endmodule

// File: rtl/sprite_palette_arbiter.sv
// Per-pixel layer priority select and palette lookup, two-stage pipeline.
module sprite_palette_arbiter
   import palette_pkg::*;
#(
   parameter int NUM_LAYERS   = 4,
   parameter int FLASH_LAYER  = 0,
   parameter int FLASH_FRAMES = 60,
   parameter int FLASH_PERIOD = 4
) (
   input  logic                                  Clk,
   input  logic                                  Reset,
   input  logic [0:NUM_COLORS-1][0:2][7:0]       palette,
   input  logic [0:NUM_LAYERS-1][IDX_W-1:0]      layer_idx,
   input  logic                                  de_in,
   input  logic                                  frame_start,
   input  logic                                  hit_pulse,
   output logic [7:0]                            VGA_R,
   output logic [7:0]                            VGA_G,
   output logic [7:0]                            VGA_B,
   output logic                                  de_out,
   output logic                                  flash_active
);

   localparam int LW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   logic             phase_on;
   logic             found;
   logic [LW-1:0]    win;
   logic [IDX_W-1:0] win_idx;
   logic [IDX_W-1:0] sel_n, sel_q;
   logic             de_s1;
   rgb_t             rgb;

   flash_ctrl #(
      .FLASH_FRAMES (FLASH_FRAMES),
      .FLASH_PERIOD (FLASH_PERIOD)
   ) u_flash (
      .clk          (Clk),
      .reset        (Reset),
      .frame_start  (frame_start),
      .hit_pulse    (hit_pulse),
      .phase_on     (phase_on),
      .flash_active (flash_active)
   );

   // Scan high to low so the lowest-numbered drawing layer is kept.
   always_comb begin
      found   = 1'b0;
      win     = '0;
      win_idx = '0;
      for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
         if (layer_idx[i] != TRANSPARENT_IDX) begin
            found   = 1'b1;
            win     = LW'(i);
            win_idx = layer_idx[i];
         end
      end
   end

   always_comb begin
      sel_n = win_idx;
      if (!de_in)
         sel_n = '0;
      else if (!found)
         sel_n = BG_IDX;
      else if (flash_active && phase_on && win == LW'(FLASH_LAYER))
         sel_n = FLASH_IDX;
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         sel_q <= '0;
         de_s1 <= 1'b0;
      end else begin
         sel_q <= sel_n;
         de_s1 <= de_in;
      end
   end

   always_comb begin
      rgb = '0;
      if (32'(sel_q) < NUM_COLORS) begin
         rgb.r = palette[sel_q][0];
         rgb.g = palette[sel_q][1];
         rgb.b = palette[sel_q][2];
      end
   end

   always_ff @(posedge Clk) begin
      if (Reset || !de_s1) begin
         VGA_R <= '0;
         VGA_G <= '0;
         VGA_B <= '0;
      end else begin
         VGA_R <= rgb.r;
         VGA_G <= rgb.g;
         VGA_B <= rgb.b;
      end
      if (Reset)
         de_out <= 1'b0;
      else
         de_out <= de_s1;
   end

endmodule

// File: tb/tb_sprite_palette_arbiter.sv
// Directed bench for sprite_palette_arbiter with hand-computed colours.
module tb_sprite_palette_arbiter;

   logic                  Clk = 1'b0;
   logic                  Reset;
   logic [0:17][0:2][7:0] pal;
   logic [0:3][4:0]       layer_idx;
   logic                  de_in;
   logic                  frame_start;
   logic                  hit_pulse;
   logic [7:0]            VGA_R, VGA_G, VGA_B;
   logic                  de_out;
   logic                  flash_active;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [23:0] BLACK  = 24'h000000;
   localparam logic [23:0] GREEN  = {8'd0, 8'd20, 8'd0};
   localparam logic [23:0] BLUE   = {8'd0, 8'd80, 8'd250};
   localparam logic [23:0] WHITE  = {8'd250, 8'd250, 8'd250};
   localparam logic [23:0] RED    = {8'd250, 8'd0, 8'd0};
   localparam logic [23:0] YELLOW = {8'd250, 8'd230, 8'd0};

   always #5 Clk = ~Clk;

   sprite_palette_arbiter dut (
      .Clk          (Clk),
      .Reset        (Reset),
      .palette      (pal),
      .layer_idx    (layer_idx),
      .de_in        (de_in),
      .frame_start  (frame_start),
      .hit_pulse    (hit_pulse),
      .VGA_R        (VGA_R),
      .VGA_G        (VGA_G),
      .VGA_B        (VGA_B),
      .de_out       (de_out),
      .flash_active (flash_active)
   );

   task automatic step();
      @(posedge Clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      assert (got === exp)
      else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic check_px(input string tag, input logic [23:0] exp,
                           input logic exp_de);
      check({tag, "_rgb"}, {8'd0, VGA_R, VGA_G, VGA_B}, {8'd0, exp});
      check({tag, "_de"}, {31'd0, de_out}, {31'd0, exp_de});
   endtask

   task automatic frames(input int n);
      for (int k = 0; k < n; k++) begin
         frame_start = 1'b1;
         step();
         frame_start = 1'b0;
         step();
      end
   endtask

   initial begin
      for (int i = 0; i < 18; i++)
         pal[i] = {8'(i + 1), 8'(i + 2), 8'(i + 3)};
      pal[2]  = GREEN;
      pal[10] = RED;
      pal[13] = BLUE;
      pal[14] = WHITE;
      pal[15] = YELLOW;
      Reset       = 1'b1;
      layer_idx   = '0;
      de_in       = 1'b0;
      frame_start = 1'b0;
      hit_pulse   = 1'b0;
      step();
      step();
      check_px("reset", BLACK, 1'b0);
      check("reset_flash", {31'd0, flash_active}, 32'd0);

      Reset = 1'b0;
      de_in = 1'b1;
      step();
      check_px("latency1", BLACK, 1'b0);
      step();
      check_px("background", GREEN, 1'b1);

      layer_idx = {5'd0, 5'd13, 5'd9, 5'd0};
      step(); step();
      check_px("layer1_wins", BLUE, 1'b1);

      pal[13] = {8'd1, 8'd2, 8'd3};
      step();
      check_px("palette_change", {8'd1, 8'd2, 8'd3}, 1'b1);
      pal[13] = BLUE;

      layer_idx = {5'd14, 5'd13, 5'd9, 5'd0};
      step(); step();
      check_px("layer0_wins", WHITE, 1'b1);

      de_in = 1'b0;
      layer_idx = {5'd15, 5'd13, 5'd9, 5'd0};
      step(); step();
      check_px("de_low", BLACK, 1'b0);

      de_in = 1'b1;
      layer_idx = {5'd20, 5'd13, 5'd9, 5'd0};
      step(); step();
      check_px("out_of_range", BLACK, 1'b1);

      layer_idx = {5'd15, 5'd0, 5'd0, 5'd0};
      hit_pulse = 1'b1;
      step();
      hit_pulse = 1'b0;
      check("hit_active", {31'd0, flash_active}, 32'd1);
      step(); step();
      check_px("flash_k0", RED, 1'b1);

      layer_idx = {5'd0, 5'd13, 5'd0, 5'd0};
      step(); step();
      check_px("flash_other_layer", BLUE, 1'b1);
      layer_idx = {5'd15, 5'd0, 5'd0, 5'd0};

      frames(3);
      step(); step();
      check_px("flash_k3", RED, 1'b1);
      frames(1);
      step(); step();
      check_px("flash_k4", YELLOW, 1'b1);
      frames(3);
      step(); step();
      check_px("flash_k7", YELLOW, 1'b1);
      frames(1);
      step(); step();
      check_px("flash_k8", RED, 1'b1);
      frames(22);
      step(); step();
      check_px("flash_k30", YELLOW, 1'b1);

      hit_pulse = 1'b1;
      step();
      hit_pulse = 1'b0;
      step(); step();
      check_px("restart_k0", RED, 1'b1);
      check("restart_active", {31'd0, flash_active}, 32'd1);

      frames(3);
      hit_pulse   = 1'b1;
      frame_start = 1'b1;
      step();
      hit_pulse   = 1'b0;
      frame_start = 1'b0;
      frames(3);
      step(); step();
      check_px("hit_and_frame", RED, 1'b1);

      frames(56);
      step(); step();
      check_px("flash_k59", RED, 1'b1);
      check("k59_active", {31'd0, flash_active}, 32'd1);
      frames(1);
      check("k60_active", {31'd0, flash_active}, 32'd0);
      step(); step();
      check_px("after_flash", YELLOW, 1'b1);

      hit_pulse = 1'b1;
      step();
      hit_pulse = 1'b0;
      frames(2);
      step(); step();
      check_px("preflash", RED, 1'b1);
      Reset = 1'b1;
      step();
      check_px("midreset", BLACK, 1'b0);
      check("midreset_flash", {31'd0, flash_active}, 32'd0);
      Reset = 1'b0;
      step();
      check_px("post_reset1", BLACK, 1'b0);
      step();
      check_px("post_reset2", YELLOW, 1'b1);
      check("post_reset_flash", {31'd0, flash_active}, 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule
